// File: rtl/aeolus_control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : aeolus_control_sequencer_if
// Description : Instruction handshake and datapath strobe bundle between the
//               instruction source and the Aeolus control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface aeolus_control_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [7:0]       instr;
  logic             alu_overflow;
  logic             ld_a;
  logic             ld_b;
  logic             alu_add;
  logic             alu_sub;
  logic             alu_lshift;
  logic             alu_rshift;
  logic             en_acc;
  logic             clr_acc;
  logic             en_out;
  logic [3:0]       imm_data;
  logic             busy;
  logic             done;
  logic             ovf_flag;
  logic             err_flag;
  logic [CNT_W-1:0] instr_count;

  // Instruction source side: issues instructions, reports ALU overflow.
  modport master (
    output start, instr, alu_overflow,
    input  ld_a, ld_b, alu_add, alu_sub, alu_lshift, alu_rshift,
    input  en_acc, clr_acc, en_out, imm_data, busy, done,
    input  ovf_flag, err_flag, instr_count
  );

  // Sequencer side.
  modport slave (
    input  start, instr, alu_overflow,
    output ld_a, ld_b, alu_add, alu_sub, alu_lshift, alu_rshift,
    output en_acc, clr_acc, en_out, imm_data, busy, done,
    output ovf_flag, err_flag, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/aeolus_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aeolus_control_sequencer
// Description : Multi-cycle control unit for the Aeolus datapath. Accepts one
//               instruction per start handshake and sequences load, ALU and
//               enable strobes; reports done, sticky overflow and error.
// Revision    : 1.0 - initial release
// ============================================================================
module aeolus_control_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  aeolus_control_sequencer_if.slave   bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_ALUWAIT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_LSL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_CLR = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [7:0]       r_instr;
  logic [3:0]       w_opcode;
  logic             r_is_alu;
  logic             r_is_clr;
  logic             r_is_illegal;
  logic             r_ovf;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  logic r_ld_a, r_ld_b, r_add, r_sub, r_lsl, r_lsr, r_en_acc, r_clr, r_en_out;
  logic r_busy, r_done;
  logic w_ld_a, w_ld_b, w_add, w_sub, w_lsl, w_lsr, w_en_acc, w_clr, w_en_out;
  logic w_busy, w_done;

  assign w_opcode = r_instr[7:4];

  // State register: reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: fixed-length sequences, ALU ops take one extra cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next_state = S_DECODE;
      S_DECODE:  w_next_state = S_EXEC;
      S_EXEC:    w_next_state = r_is_alu ? S_ALUWAIT : S_DONE;
      S_ALUWAIT: w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the registered strobes line up
  // exactly with the state they belong to. r_instr is stable from DECODE on.
  always_comb begin
    w_ld_a   = 1'b0;
    w_ld_b   = 1'b0;
    w_add    = 1'b0;
    w_sub    = 1'b0;
    w_lsl    = 1'b0;
    w_lsr    = 1'b0;
    w_en_acc = 1'b0;
    w_clr    = 1'b0;
    w_en_out = 1'b0;
    w_busy   = (w_next_state != S_IDLE);
    w_done   = (w_next_state == S_DONE);
    if (w_next_state == S_EXEC) begin
      case (w_opcode)
        OP_LDA:  w_ld_a   = 1'b1;
        OP_LDB:  w_ld_b   = 1'b1;
        OP_ADD:  w_add    = 1'b1;
        OP_SUB:  w_sub    = 1'b1;
        OP_LSL:  w_lsl    = 1'b1;
        OP_LSR:  w_lsr    = 1'b1;
        OP_CLR:  w_clr    = 1'b1;
        OP_OUT:  w_en_out = 1'b1;
        default: ;
      endcase
    end
    if (w_next_state == S_ALUWAIT) w_en_acc = 1'b1;
  end

  // Output register stage: glitch-free Moore strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_a   <= 1'b0;
      r_ld_b   <= 1'b0;
      r_add    <= 1'b0;
      r_sub    <= 1'b0;
      r_lsl    <= 1'b0;
      r_lsr    <= 1'b0;
      r_en_acc <= 1'b0;
      r_clr    <= 1'b0;
      r_en_out <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ld_a   <= w_ld_a;
      r_ld_b   <= w_ld_b;
      r_add    <= w_add;
      r_sub    <= w_sub;
      r_lsl    <= w_lsl;
      r_lsr    <= w_lsr;
      r_en_acc <= w_en_acc;
      r_clr    <= w_clr;
      r_en_out <= w_en_out;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  // Instruction latch on accepted start, and opcode class decode in DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr      <= 8'h00;
      r_is_alu     <= 1'b0;
      r_is_clr     <= 1'b0;
      r_is_illegal <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.start) r_instr <= bus.instr;
      if (r_state == S_DECODE) begin
        r_is_alu     <= (w_opcode >= OP_ADD) && (w_opcode <= OP_LSR);
        r_is_clr     <= (w_opcode == OP_CLR);
        r_is_illegal <= (w_opcode > OP_OUT);
      end
    end
  end

  // Sticky status: CLR clears overflow in EXEC, and never reaches ALUWAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_EXEC && r_is_illegal) r_err <= 1'b1;
      if (r_state == S_EXEC && r_is_clr)     r_ovf <= 1'b0;
      else if (r_state == S_ALUWAIT)         r_ovf <= r_ovf | bus.alu_overflow;
    end
  end

  // Retired-instruction counter: bumps as DONE is left, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)                 r_count <= '0;
    else if (r_state == S_DONE) r_count <= r_count + CNT_ONE;
  end

  assign bus.ld_a        = r_ld_a;
  assign bus.ld_b        = r_ld_b;
  assign bus.alu_add     = r_add;
  assign bus.alu_sub     = r_sub;
  assign bus.alu_lshift  = r_lsl;
  assign bus.alu_rshift  = r_lsr;
  assign bus.en_acc      = r_en_acc;
  assign bus.clr_acc     = r_clr;
  assign bus.en_out      = r_en_out;
  assign bus.imm_data    = r_instr[3:0];
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.ovf_flag    = r_ovf;
  assign bus.err_flag    = r_err;
  assign bus.instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_aeolus_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aeolus_control_sequencer
// Description : Scoreboard bench for aeolus_control_sequencer. Two instances
//               (CNT_W=8 and CNT_W=2) share one instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aeolus_control_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aeolus_control_sequencer_if #(.CNT_W(8)) bus ();
  aeolus_control_sequencer_if #(.CNT_W(2)) bus2 ();

  assign bus2.start        = bus.start;
  assign bus2.instr        = bus.instr;
  assign bus2.alu_overflow = bus.alu_overflow;

  aeolus_control_sequencer #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  aeolus_control_sequencer #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // Strobe word: {ld_a, ld_b, add, sub, lsl, lsr, en_acc, clr_acc, en_out}
  localparam logic [8:0] SW_EN_ACC = 9'b0_0000_0100;
  logic [8:0] sw;
  assign sw = {bus.ld_a, bus.ld_b, bus.alu_add, bus.alu_sub, bus.alu_lshift,
               bus.alu_rshift, bus.en_acc, bus.clr_acc, bus.en_out};

  typedef struct packed {
    logic [3:0] imm;
    logic [8:0] s2;
    logic [8:0] s3;
    logic [2:0] done_cyc;
    logic       ovf;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state
  logic m_ovf = 1'b0;
  logic m_err = 1'b0;
  int   m_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] strobe_for(input logic [3:0] op);
    case (op)
      4'h1:    return 9'b1_0000_0000;
      4'h2:    return 9'b0_1000_0000;
      4'h3:    return 9'b0_0100_0000;
      4'h4:    return 9'b0_0010_0000;
      4'h5:    return 9'b0_0001_0000;
      4'h6:    return 9'b0_0000_1000;
      4'h7:    return 9'b0_0000_0010;
      4'h8:    return 9'b0_0000_0001;
      default: return 9'b0;
    endcase
  endfunction

  task automatic push_exp(input logic [7:0] ins, input logic ovf_in);
    exp_t e;
    logic [3:0] op;
    logic alu;
    op  = ins[7:4];
    alu = (op >= 4'h3) && (op <= 4'h6);
    if (alu) m_ovf = m_ovf | ovf_in;
    if (op == 4'h7) m_ovf = 1'b0;
    if (op > 4'h8) m_err = 1'b1;
    m_count++;
    e.imm      = ins[3:0];
    e.s2       = strobe_for(op);
    e.s3       = alu ? SW_EN_ACC : 9'b0;
    e.done_cyc = alu ? 3'd4 : 3'd3;
    e.ovf      = m_ovf;
    e.err      = m_err;
    e.cnt      = m_count[7:0];
    e.cnt2     = m_count[1:0];
    q.push_back(e);
  endtask

  // Monitor: tracks cycles since acceptance, compares on done.
  int         cyc = 0;
  logic [8:0] sw_hist [0:7];
  logic [3:0] imm1;
  exp_t       cur;
  bit         pend = 0;

  always @(negedge clk) begin
    if (reset) begin
      cyc  = 0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("count", bus.instr_count, cur.cnt);
        chk("count_w2", bus2.instr_count, cur.cnt2);
        chk("busy_after_done", bus.busy, 0);
        pend = 0;
      end
      if (bus.busy) cyc++;
      else cyc = 0;
      if (cyc < 8) sw_hist[cyc] = sw;
      if (cyc == 1) imm1 = bus.imm_data;
      if (bus.done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no instruction pending");
        end else begin
          cur = q.pop_front();
          chk("done_cycle", cyc, cur.done_cyc);
          chk("strobes_decode", sw_hist[1], 0);
          chk("strobes_exec", sw_hist[2], cur.s2);
          chk("strobes_cycle3", sw_hist[3], cur.s3);
          chk("strobes_done", sw, 0);
          chk("imm_decode", imm1, cur.imm);
          chk("imm_done", bus.imm_data, cur.imm);
          chk("ovf_flag", bus.ovf_flag, cur.ovf);
          chk("err_flag", bus.err_flag, cur.err);
          pend = 1;
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("wait_idle", bus.busy, 0);
  endtask

  task automatic issue(input logic [7:0] ins, input logic ovf_in);
    push_exp(ins, ovf_in);
    @(negedge clk);
    bus.instr = ins;
    bus.start = 1'b1;
    bus.alu_overflow = ovf_in;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle();
    bus.alu_overflow = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    bus.start = 1'b0;
    bus.instr = 8'h00;
    bus.alu_overflow = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_strobes", sw, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_imm", bus.imm_data, 0);
    chk("rst_ovf", bus.ovf_flag, 0);
    chk("rst_err", bus.err_flag, 0);
    chk("rst_count", bus.instr_count, 0);
    chk("rst_count_w2", bus2.instr_count, 0);

    // Overflow input must be ignored outside ALUWAIT
    issue(8'h15, 1'b1);
    issue(8'h30, 1'b1);
    issue(8'h40, 1'b0);
    issue(8'h70, 1'b0);
    issue(8'h2C, 1'b0);
    issue(8'h51, 1'b0);
    issue(8'h62, 1'b1);
    issue(8'h80, 1'b0);
    issue(8'hA3, 1'b0);
    issue(8'h00, 1'b0);
    issue(8'hF7, 1'b0);

    // start held/pulsed during an ADD: only the first is accepted
    push_exp(8'h31, 1'b0);
    @(negedge clk);
    bus.instr = 8'h31;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk) bus.instr = 8'h15;
    @(negedge clk) bus.instr = 8'h80;
    @(negedge clk) bus.instr = 8'h70;
    @(negedge clk) bus.instr = 8'h20;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle();

    // start held high: next instruction taken on first IDLE after DONE
    push_exp(8'h02, 1'b0);
    push_exp(8'h03, 1'b0);
    @(negedge clk);
    bus.instr = 8'h02;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.instr = 8'h03;
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle();

    // Reset in ALUWAIT aborts the instruction
    @(negedge clk);
    bus.instr = 8'h31;
    bus.start = 1'b1;
    bus.alu_overflow = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("aluwait_en_acc", bus.en_acc, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_en_acc", bus.en_acc, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_count", bus.instr_count, 0);
    chk("abort_ovf", bus.ovf_flag, 0);
    chk("abort_err", bus.err_flag, 0);
    chk("abort_imm", bus.imm_data, 0);
    reset = 1'b0;
    bus.alu_overflow = 1'b0;
    m_ovf = 1'b0;
    m_err = 1'b0;
    m_count = 0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", bus.done, 0);

    // Five NOPs: 2-bit counter wraps to 1
    for (int i = 0; i < 5; i++) issue(8'h00, 1'b0);
    chk("wrap_count_w2", bus2.instr_count, 1);
    chk("count_after_nops", bus.instr_count, 5);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
